keypad_scan_ctrl: RTL and testbench

Sequencing controller for the 4x4 keypad row scanner. It paces the row stepper with a one-cycle `row_en` strobe and freezes it with `row_hold` while a key is being resolved. It samples the column lines, debounces press and release, and emits one `key_valid` pulse with a 4-bit key code per debounced press. It sits between the keypad pins and the display/decoder logic, alongside the row stepper.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_scan_ctrl_if.sv | 21 ++
 rtl/col_sync.sv | 24 ++
 rtl/keypad_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and index helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    KS_SCAN,
    KS_DEBOUNCE,
    KS_HELD,
    KS_RELEASE
  } kscan_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] onehot);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (onehot[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Walks downward so the lowest set bit is the last one written.
  function automatic logic [1:0] lowest_set_idx(input logic [3:0] vec);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (vec[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin / row-stepper / decoder signal bundle seen by the scan controller.
interface keypad_scan_ctrl_if;

  logic [3:0]                   row_in;
  logic [3:0]                   cols;
  logic                         row_en;
  logic                         row_hold;
  logic [keypad_pkg::KEY_W-1:0] key_code;
  logic                         key_valid;

  modport master (
    input  row_in, cols,
    output row_en, row_hold, key_code, key_valid
  );

  modport slave (
    output row_in, cols,
    input  row_en, row_hold, key_code, key_valid
  );

endinterface

// File: rtl/col_sync.sv
// Two-flop synchronizer for the four keypad column lines.
module col_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan sequencer: paces the row stepper, debounces press/release, emits key codes.
// Define KEYPAD_SYNC_EN to pass the column lines through a two-flop synchronizer.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input logic                clk,
  input logic                reset,
  keypad_scan_ctrl_if.master kp_if
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_PRE   = DB_W'(DEBOUNCE_CYCLES - 2);

  kscan_state_t     state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic             row_en_q, row_en_d;
  logic             row_hold_q, row_hold_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;

  logic [3:0] cols_s;
  logic       col_hit;
  logic       row_onehot;

`ifdef KEYPAD_SYNC_EN
  col_sync u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (kp_if.cols),
    .q_o   (cols_s)
  );
`else
  assign cols_s = kp_if.cols;
`endif

  assign col_hit    = cols_s[col_idx_q];
  assign row_onehot = (kp_if.row_in != 4'd0) &&
                      ((kp_if.row_in & (kp_if.row_in - 4'd1)) == 4'd0);

  // The decision sample counts as the first debounce sample, hence the PRE compare.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    db_d        = db_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    row_en_d    = 1'b0;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    unique case (state_q)
      KS_SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if ((cols_s != 4'd0) && row_onehot) begin
            state_d   = KS_DEBOUNCE;
            db_d      = '0;
            row_idx_d = onehot_to_idx(kp_if.row_in);
            col_idx_d = lowest_set_idx(cols_s);
          end else begin
            row_en_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      KS_DEBOUNCE: begin
        if (!col_hit) begin
          state_d = KS_SCAN;
          div_d   = '0;
        end else begin
          if (db_q != DB_LAST) db_d = db_q + 1'b1;
          if (db_q == DB_PRE) begin
            state_d     = KS_HELD;
            key_valid_d = 1'b1;
            key_code_d  = {row_idx_q, col_idx_q};
          end
        end
      end
      KS_HELD: begin
        if (!col_hit) begin
          state_d = KS_RELEASE;
          db_d    = '0;
        end
      end
      KS_RELEASE: begin
        if (col_hit) begin
          state_d = KS_HELD;
        end else begin
          if (db_q != DB_LAST) db_d = db_q + 1'b1;
          if (db_q == DB_PRE) begin
            state_d = KS_SCAN;
            div_d   = '0;
          end
        end
      end
      default: state_d = KS_SCAN;
    endcase

    row_hold_d = (state_d != KS_SCAN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= KS_SCAN;
      div_q       <= '0;
      db_q        <= '0;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      row_en_q    <= 1'b0;
      row_hold_q  <= 1'b0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      db_q        <= db_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      row_en_q    <= row_en_d;
      row_hold_q  <= row_hold_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kp_if.row_en    = row_en_q;
  assign kp_if.row_hold  = row_hold_q;
  assign kp_if.key_code  = key_code_q;
  assign kp_if.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: row-stepper and keypad models drive the DUT,
// a sample-counting reference model predicts every output cycle by cycle.
module tb_keypad_scan_ctrl;
   import keypad_pkg::*;

   localparam int SCAN_DIV = 4;
   localparam int DC       = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;

   keypad_scan_ctrl_if kif();

   keypad_scan_ctrl #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp_if (kif.master)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;

   // Keypad stimulus state: which key row is pressed and which columns it closes
   int         pressRow    = 0;
   logic [3:0] pressMask   = 4'd0;
   bit         pressActive = 1'b0;
   bit         bounce      = 1'b0;

   // Reference model state, counted in samples rather than register encodings
   int         mPhase = 0;
   int         mTick  = 0;
   int         mRun   = 0;
   int         mRow   = 0;
   int         mCol   = 0;
   logic [3:0] hist0  = 4'd0;
   logic [3:0] hist1  = 4'd0;
   logic       expRowEn    = 1'b0;
   logic       expRowHold  = 1'b0;
   logic       expKeyValid = 1'b0;
   logic [3:0] expKeyCode  = 4'd0;

   // Monitor counters kept by the compare process
   bit cmpOn       = 1'b0;
   int cyc         = 0;
   int rowEnCount  = 0;
   int kvCount     = 0;
   int holdRiseCyc = -1;
   int kvCyc       = -1;
   logic prevHold  = 1'b0;

   task automatic checkOutput(input string name, input int act, input int req);
      checkCount++;
      if (act == req) passCount++;
      else $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic int lowestOf(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   // One clock of the reference model, using the inputs the DUT samples on this edge
   task automatic modelStep();
      logic [3:0] s;
      if (reset) begin
         mPhase = 0; mTick = 0; mRun = 0; mRow = 0; mCol = 0;
         hist0 = 4'd0; hist1 = 4'd0;
         expRowEn = 1'b0; expRowHold = 1'b0; expKeyValid = 1'b0; expKeyCode = 4'd0;
         return;
      end
`ifdef KEYPAD_SYNC_EN
      s = hist1;
      hist1 = hist0;
      hist0 = kif.cols;
`else
      s = kif.cols;
`endif
      expRowEn = 1'b0;
      expKeyValid = 1'b0;
      case (mPhase)
         0: begin
            mTick++;
            if (mTick == SCAN_DIV) begin
               mTick = 0;
               if (s != 4'd0 && $onehot(kif.row_in)) begin
                  mPhase = 1;
                  mRun = 1;
                  mRow = $clog2(kif.row_in);
                  mCol = lowestOf(s);
               end else begin
                  expRowEn = 1'b1;
               end
            end
         end
         1: begin
            if (s[mCol]) begin
               mRun++;
               if (mRun == DC) begin
                  mPhase = 2;
                  expKeyValid = 1'b1;
                  expKeyCode = 4'(mRow * 4 + mCol);
               end
            end else begin
               mPhase = 0;
               mTick = 0;
            end
         end
         2: begin
            if (!s[mCol]) begin
               mPhase = 3;
               mRun = 1;
            end
         end
         default: begin
            if (s[mCol]) mPhase = 2;
            else begin
               mRun++;
               if (mRun == DC) begin
                  mPhase = 0;
                  mTick = 0;
               end
            end
         end
      endcase
      expRowHold = (mPhase != 0);
   endtask

   // Advance one cycle: model on the rising edge, then the row stepper and keypad react
   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      #1;
      if (reset) kif.row_in = 4'b0001;
      else if (kif.row_en) kif.row_in = {kif.row_in[2:0], kif.row_in[3]};
      kif.cols = (pressActive && !bounce && kif.row_in[pressRow]) ? pressMask : 4'd0;
   endtask

   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic waitHold(input int budget);
      int n = 0;
      while (!kif.row_hold && n < budget) begin
         tick();
         n++;
      end
      checkOutput("hold_rise_wait", int'(kif.row_hold), 1);
   endtask

   // Compare process: every cycle after reset, DUT outputs against the model
   always @(negedge clk) begin
      if (cmpOn) begin
         cyc++;
         checkOutput("row_en", int'(kif.row_en), int'(expRowEn));
         checkOutput("row_hold", int'(kif.row_hold), int'(expRowHold));
         checkOutput("key_valid", int'(kif.key_valid), int'(expKeyValid));
         checkOutput("key_code", int'(kif.key_code), int'(expKeyCode));
         if (kif.row_en === 1'b1) rowEnCount++;
         if (kif.key_valid === 1'b1) begin
            kvCount++;
            kvCyc = cyc;
         end
         if (kif.row_hold === 1'b1 && prevHold !== 1'b1) holdRiseCyc = cyc;
         prevHold = kif.row_hold;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout actual=running required=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      int reBase, kvBase, len;
      kif.row_in = 4'b0001;
      kif.cols   = 4'd0;
      reset = 1'b1;
      tick();
      cmpOn = 1'b1;
      applyStimulus(2);
      checkOutput("reset_row_hold", int'(kif.row_hold), 0);
      checkOutput("reset_key_code", int'(kif.key_code), 0);
      checkOutput("reset_row_en", int'(kif.row_en), 0);
      reset = 1'b0;

      // Idle scanning: one row_en every SCAN_DIV cycles
      reBase = rowEnCount;
      kvBase = kvCount;
      applyStimulus(40);
      checkOutput("idle_row_en_pulses", rowEnCount - reBase, 10);
      checkOutput("idle_key_valid", kvCount - kvBase, 0);
      checkOutput("idle_key_code", int'(kif.key_code), 0);

      // Clean press of row 1, column 2
      $display("[TB] press row1 col2");
      pressRow = 1; pressMask = 4'b0100; pressActive = 1'b1;
      kvBase = kvCount;
      waitHold(40);
      reBase = rowEnCount;
      applyStimulus(12);
      checkOutput("press_key_valid_count", kvCount - kvBase, 1);
      checkOutput("press_key_code", int'(kif.key_code), 6);
      checkOutput("press_latency", kvCyc - holdRiseCyc, DC - 1);
      checkOutput("press_row_en_frozen", rowEnCount - reBase, 0);
      pressActive = 1'b0;
      applyStimulus(20);
      checkOutput("release_row_hold", int'(kif.row_hold), 0);

      // Short glitch on row 0 never becomes a key
      $display("[TB] glitch row0 col0");
      pressRow = 0; pressMask = 4'b0001; pressActive = 1'b1;
      kvBase = kvCount;
      waitHold(40);
      applyStimulus(1);
      pressActive = 1'b0;
      reBase = rowEnCount;
      applyStimulus(20);
      checkOutput("glitch_key_valid", kvCount - kvBase, 0);
      checkOutput("glitch_row_hold", int'(kif.row_hold), 0);
      checkOutput("glitch_row_en_resumes", int'(rowEnCount > reBase), 1);

      // Two columns, lowest wins; bounce during hold gives no second key
      $display("[TB] press row2 cols 1010 with bounce");
      pressRow = 2; pressMask = 4'b1010; pressActive = 1'b1;
      kvBase = kvCount;
      waitHold(40);
      applyStimulus(10);
      checkOutput("multi_key_code", int'(kif.key_code), 9);
      bounce = 1'b1;
      applyStimulus(3);
      bounce = 1'b0;
      applyStimulus(6);
      pressActive = 1'b0;
      applyStimulus(16);
      checkOutput("bounce_key_valid_count", kvCount - kvBase, 1);
      checkOutput("bounce_release_hold", int'(kif.row_hold), 0);

      // Reset while debouncing
      $display("[TB] reset during debounce");
      pressRow = 3; pressMask = 4'b0100; pressActive = 1'b1;
      waitHold(40);
      applyStimulus(2);
      reset = 1'b1;
      kvBase = kvCount;
      tick();
      checkOutput("rst_row_hold", int'(kif.row_hold), 0);
      checkOutput("rst_key_valid", int'(kif.key_valid), 0);
      checkOutput("rst_key_code", int'(kif.key_code), 0);
      pressActive = 1'b0;
      reset = 1'b0;
      applyStimulus(10);
      checkOutput("rst_no_key", kvCount - kvBase, 0);

      // Randomized presses with bounce and occasional reset
      $display("[TB] random episodes");
      for (int e = 0; e < 40; e++) begin
         pressRow    = $urandom_range(0, 3);
         pressMask   = 4'($urandom_range(1, 15));
         pressActive = 1'b1;
         len = $urandom_range(0, 40);
         for (int c = 0; c < len; c++) begin
            bounce = ($urandom_range(0, 7) == 0);
            reset  = ($urandom_range(0, 199) == 0);
            tick();
         end
         bounce = 1'b0;
         reset = 1'b0;
         pressActive = 1'b0;
         applyStimulus($urandom_range(5, 25));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
